// File: rtl/fifo_pkg.sv
`default_nettype none
//==============================================================================
// Module      : fifo_pkg
// Description : Shared helpers for the async FIFO pointer blocks: Gray/binary
//               conversion functions that take the pointer width as an
//               argument, plus the reset values of the read-side status flags.
// Revision    : 1.0 - initial release
//==============================================================================
package fifo_pkg;

    // Reset values of the read-side status flags (FIFO starts empty).
    localparam logic RST_EMPTY        = 1'b1;
    localparam logic RST_ALMOST_EMPTY = 1'b1;
    localparam logic RST_UNDERFLOW    = 1'b0;

    // Binary to Gray over the low w bits; bits at and above w are returned as 0.
    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
        logic [31:0] g;
        logic [31:0] s;
        g = '0;
        s = b >> 1;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                g[i] = b[i] ^ (((i + 1) < w) ? s[i] : 1'b0);
            end
        end
        return g;
    endfunction

    // Gray to binary over the low w bits (XOR prefix from the MSB down).
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
        logic [31:0] b;
        logic        acc;
        b   = '0;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (i < w) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/rptr_empty_lvl_if.sv
`default_nettype none
//==============================================================================
// Module      : rptr_empty_lvl_if
// Description : Read-side bundle of the async FIFO. The master modport is the
//               consumer/synchronizer side; the slave modport is the
//               rptr_empty_lvl block.
//   rpop_n        words requested this cycle (0 = none)
//   rae_thresh    almost-empty threshold
//   rq2_wptr      Gray write pointer in the read clock domain
//   rptr          registered Gray read pointer
//   raddr         memory read address
//   rpop_acc      request accepted this cycle (combinational)
//   rlevel        registered fill level
//   rempty        registered empty flag
//   ralmost_empty registered almost-empty flag
//   runderflow    one-cycle pulse on a rejected pop
// Revision    : 1.0 - initial release
//==============================================================================
interface rptr_empty_lvl_if #(
    parameter int ADDRSIZE = 4,
    parameter int MAXPOP   = 4
);
    localparam int POPW = $clog2(MAXPOP + 1);

    logic [POPW-1:0]     rpop_n;
    logic [ADDRSIZE:0]   rae_thresh;
    logic [ADDRSIZE:0]   rq2_wptr;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE-1:0] raddr;
    logic                rpop_acc;
    logic [ADDRSIZE:0]   rlevel;
    logic                rempty;
    logic                ralmost_empty;
    logic                runderflow;

    modport master (
        output rpop_n, rae_thresh, rq2_wptr,
        input  rptr, raddr, rpop_acc, rlevel, rempty, ralmost_empty, runderflow
    );

    modport slave (
        input  rpop_n, rae_thresh, rq2_wptr,
        output rptr, raddr, rpop_acc, rlevel, rempty, ralmost_empty, runderflow
    );

endinterface : rptr_empty_lvl_if
`default_nettype wire

// File: rtl/gray2bin_conv.sv
`default_nettype none
//==============================================================================
// Module      : gray2bin_conv
// Description : Combinational Gray-to-binary converter. Each binary bit is the
//               XOR of all Gray bits at and above its position.
//   gray_i  W-bit Gray code in
//   bin_o   W-bit binary out
// Revision    : 1.0 - initial release
//==============================================================================
module gray2bin_conv #(
    parameter int W = 5
) (
    input  wire logic [W-1:0] gray_i,
    output logic      [W-1:0] bin_o
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[W-1:i];
    end

endmodule : gray2bin_conv
`default_nettype wire

// File: rtl/rptr_empty_lvl.sv
`default_nettype none
//==============================================================================
// Module      : rptr_empty_lvl
// Description : Read-side pointer and status block of the async FIFO. Accepts
//               all-or-nothing multi-word pops against the registered fill
//               level, keeps a binary read counter plus a registered Gray read
//               pointer, and produces level, empty, almost-empty and underflow.
//   rclk    read clock
//   rrst_n  synchronous active-low reset
//   bus     rptr_empty_lvl_if.slave (pop request, threshold, synchronized
//           write pointer in; read pointer, address and status out)
// Optional    : RPTR_INT_SYNC_EN - when defined, bus.rq2_wptr is the raw
//               write-domain Gray pointer and is passed through two internal
//               rclk flops before use.
// Revision    : 1.0 - initial release
//==============================================================================
module rptr_empty_lvl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = 4,
    parameter int MAXPOP   = 4
) (
    input  wire logic         rclk,
    input  wire logic         rrst_n,
    rptr_empty_lvl_if.slave   bus
);

    localparam int PW   = ADDRSIZE + 1;
    localparam int POPW = $clog2(MAXPOP + 1);

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rgray_d;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          rempty_q, rempty_d;
    logic          raempty_q, raempty_d;
    logic          runder_q, runder_d;

    logic [PW-1:0] wptr_use;
    logic [PW-1:0] wbin;
    logic [PW-1:0] pop_ext;
    logic [PW-1:0] grant;
    logic          pop_req;
    logic          pop_acc;

`ifdef RPTR_INT_SYNC_EN
    // Two-flop synchronizer for the raw write-domain Gray pointer.
    logic [PW-1:0] wsync1_q, wsync2_q;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            wsync1_q <= '0;
            wsync2_q <= '0;
        end else begin
            wsync1_q <= bus.rq2_wptr;
            wsync2_q <= wsync1_q;
        end
    end

    assign wptr_use = wsync2_q;
`else
    assign wptr_use = bus.rq2_wptr;
`endif

    gray2bin_conv #(.W(PW)) u_wbin (
        .gray_i (wptr_use),
        .bin_o  (wbin)
    );

    // Acceptance uses the registered level; the write pointer only moves
    // forward, so the true occupancy is never below it. Oversized requests
    // (beyond MAXPOP) are rejected outright.
    always_comb begin
        pop_ext = PW'(bus.rpop_n);
        pop_req = (bus.rpop_n != '0);
        pop_acc = pop_req
                  && (bus.rpop_n <= POPW'(MAXPOP))
                  && (pop_ext <= rlevel_q);
        grant   = pop_acc ? pop_ext : '0;
    end

    always_comb begin
        rbin_d    = rbin_q + grant;
        rgray_d   = PW'(bin2gray(32'(rbin_d), PW));
        rlevel_d  = wbin - rbin_d;
        rempty_d  = (rgray_d == wptr_use);
        raempty_d = (rlevel_d <= bus.rae_thresh);
        runder_d  = pop_req && !pop_acc;
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rlevel_q  <= '0;
            rempty_q  <= RST_EMPTY;
            raempty_q <= RST_ALMOST_EMPTY;
            runder_q  <= RST_UNDERFLOW;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rgray_d;
            rlevel_q  <= rlevel_d;
            rempty_q  <= rempty_d;
            raempty_q <= raempty_d;
            runder_q  <= runder_d;
        end
    end

    assign bus.rptr          = rptr_q;
    assign bus.raddr         = rbin_q[ADDRSIZE-1:0];
    assign bus.rpop_acc      = pop_acc;
    assign bus.rlevel        = rlevel_q;
    assign bus.rempty        = rempty_q;
    assign bus.ralmost_empty = raempty_q;
    assign bus.runderflow    = runder_q;

endmodule : rptr_empty_lvl
`default_nettype wire
